pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 64, width of all jump/trap addresses.
REQ-002 Parameter: CNT_W, default 32, width of stall cycle counter.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 trap_req_i  input  1  exception/interrupt redirect request (highest priority).
REQ-006 trap_addr_i  input  ADDR_W  trap vector target.
REQ-007 ex_jump_req_i  input  1  branch taken / JAL / JALR resolved in EX.
REQ-008 ex_jump_addr_i  input  ADDR_W  EX redirect target.
REQ-009 mdu_start_i  input  1  multi-cycle mul/div issued from EX.
REQ-010 mdu_done_i  input  1  mul/div result valid this cycle.
REQ-011 load_use_i  input  1  load-use hazard detected in ID.
REQ-012 ifetch_ready_i  input  1  instruction bus can accept a fetch this cycle.
REQ-013 jump_en_o  output  1  PC redirect strobe.
REQ-014 jump_addr_o  output  ADDR_W  PC redirect target.
REQ-015 hold_o  output  3  stall level: 0 none, 1 PC, 2 PC+IF/ID, 3 PC+IF/ID+ID/EX.
REQ-016 flush_o  output  2  bit0 flush IF/ID, bit1 flush ID/EX.
REQ-017 mdu_kill_o  output  1  abort in-flight mul/div, single-cycle pulse.
REQ-018 stall_cnt_o  output  CNT_W  count of cycles with hold_o != 0.

Function
REQ-019 States: RUN, MDU_WAIT, JUMP_PEND; one registered state variable, registered pend_addr (ADDR_W).
REQ-020 jump_en_o, jump_addr_o, hold_o, flush_o, mdu_kill_o combinational from state and current inputs; zero-cycle latency.
REQ-021 Defaults every cycle unless overridden: jump_en_o 0, jump_addr_o 0, hold_o 0, flush_o 0, mdu_kill_o 0.
REQ-022 RUN priority: trap_req_i > ex_jump_req_i > mdu_start_i > load_use_i > !ifetch_ready_i.
REQ-023 RUN, redirect (trap or ex_jump) with ifetch_ready_i=1: jump_en_o 1, jump_addr_o selected target, flush_o 2'b11; stay RUN.
REQ-024 RUN, redirect with ifetch_ready_i=0: pend_addr <= selected target, flush_o 2'b11, hold_o 1, -> JUMP_PEND.
REQ-025 RUN, mdu_start_i (no redirect): hold_o 3, -> MDU_WAIT; if mdu_done_i also 1 same cycle, hold_o 0, stay RUN.
REQ-026 RUN, load_use_i (no higher): hold_o 2, flush_o 2'b10; stay RUN.
REQ-027 RUN, ifetch_ready_i=0 (no higher): hold_o 1, flush_o 2'b01; stay RUN.
REQ-028 MDU_WAIT, trap_req_i: mdu_kill_o 1, then behave as REQ-023/REQ-024 for trap target (RUN or JUMP_PEND).
REQ-029 MDU_WAIT, mdu_done_i (no trap): hold_o 0, -> RUN.
REQ-030 MDU_WAIT otherwise: hold_o 3; ex_jump_req_i, load_use_i, mdu_start_i ignored.
REQ-031 JUMP_PEND, trap_req_i: pend_addr <= trap_addr_i; redirect targets trap_addr_i this cycle if ifetch_ready_i=1.
REQ-032 JUMP_PEND, ifetch_ready_i=1: jump_en_o 1, jump_addr_o pend_addr (or trap_addr_i per REQ-031), flush_o 2'b11, -> RUN.
REQ-033 JUMP_PEND, ifetch_ready_i=0: hold_o 1, flush_o 2'b11, stay; ex_jump_req_i, mdu_start_i, load_use_i ignored.
REQ-034 Addresses passed unmodified, no alignment masking.
REQ-035 stall_cnt_o increments by 1 each cycle hold_o != 0; saturates at all-ones, no wrap.

Reset
REQ-036 rst_n=0 at clock edge: state RUN, pend_addr 0, stall_cnt_o 0.
REQ-037 While rst_n=0: jump_en_o 0, hold_o 0, mdu_kill_o 0, flush_o 2'b11, all inputs ignored.
REQ-038 Reset in MDU_WAIT or JUMP_PEND abandons operation; no mdu_kill_o pulse, no redirect.

Verification
REQ-039 RUN, ex_jump_req_i=1, addr 0x80000100, ifetch_ready_i=1 -> same cycle jump_en_o 1, jump_addr_o 0x80000100, flush_o 11, hold_o 0.
REQ-040 mdu_start_i pulse, mdu_done_i 5 cycles later -> hold_o 3 for 5 cycles, 0 on done cycle, stall_cnt_o +5.
REQ-041 MDU_WAIT for 2 cycles, trap_req_i=1 addr 0x100, ifetch_ready_i=1 -> mdu_kill_o 1 one cycle, jump_en_o 1 addr 0x100, state RUN.
REQ-042 ex_jump addr 0x2000 with ifetch_ready_i=0 for 3 cycles -> hold_o 1, jump_en_o 0 for 3 cycles; 4th cycle jump_en_o 1 addr 0x2000; trap 0x300 injected cycle 2 -> redirect to 0x300.
REQ-043 trap_req_i, ex_jump_req_i, load_use_i all 1 in RUN -> jump_addr_o = trap_addr_i, hold_o 0, flush_o 11.
REQ-044 CNT_W=4, hold 20 cycles -> stall_cnt_o stops at 15; rst_n=0 mid-MDU_WAIT -> next cycle state RUN, stall_cnt_o 0, flush_o 11 during reset.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - redirect/stall request and control bundle for pipe_ctrl
interface pipe_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
);
  logic              trap_req_i;
  logic [ADDR_W-1:0] trap_addr_i;
  logic              ex_jump_req_i;
  logic [ADDR_W-1:0] ex_jump_addr_i;
  logic              mdu_start_i;
  logic              mdu_done_i;
  logic              load_use_i;
  logic              ifetch_ready_i;
  logic              jump_en_o;
  logic [ADDR_W-1:0] jump_addr_o;
  logic [2:0]        hold_o;
  logic [1:0]        flush_o;
  logic              mdu_kill_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output trap_req_i, trap_addr_i, ex_jump_req_i, ex_jump_addr_i,
    output mdu_start_i, mdu_done_i, load_use_i, ifetch_ready_i,
    input  jump_en_o, jump_addr_o, hold_o, flush_o, mdu_kill_o, stall_cnt_o
  );

  modport slave (
    input  trap_req_i, trap_addr_i, ex_jump_req_i, ex_jump_addr_i,
    input  mdu_start_i, mdu_done_i, load_use_i, ifetch_ready_i,
    output jump_en_o, jump_addr_o, hold_o, flush_o, mdu_kill_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline redirect, stall and flush controller
module pipe_ctrl #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MDU_WAIT  = 2'd1,
    JUMP_PEND = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic [2:0]        hold;
  logic [1:0]        flush;
  logic              mdu_kill;

  logic              redirect;
  logic [ADDR_W-1:0] redir_tgt;

  // Trap outranks the EX-resolved jump whenever both are present.
  assign redirect  = bus.trap_req_i | bus.ex_jump_req_i;
  assign redir_tgt = bus.trap_req_i ? bus.trap_addr_i : bus.ex_jump_addr_i;

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    jump_en     = 1'b0;
    jump_addr   = '0;
    hold        = 3'd0;
    flush       = 2'b00;
    mdu_kill    = 1'b0;

    if (!rst_n) begin
      flush   = 2'b11;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (redirect) begin
            flush = 2'b11;
            if (bus.ifetch_ready_i) begin
              jump_en   = 1'b1;
              jump_addr = redir_tgt;
            end else begin
              hold        = 3'd1;
              pend_addr_d = redir_tgt;
              state_d     = JUMP_PEND;
            end
          end else if (bus.mdu_start_i) begin
            // A same-cycle done means the result is already there: no stall.
            if (!bus.mdu_done_i) begin
              hold    = 3'd3;
              state_d = MDU_WAIT;
            end
          end else if (bus.load_use_i) begin
            hold  = 3'd2;
            flush = 2'b10;
          end else if (!bus.ifetch_ready_i) begin
            hold  = 3'd1;
            flush = 2'b01;
          end
        end

        MDU_WAIT: begin
          if (bus.trap_req_i) begin
            mdu_kill = 1'b1;
            flush    = 2'b11;
            if (bus.ifetch_ready_i) begin
              jump_en   = 1'b1;
              jump_addr = bus.trap_addr_i;
              state_d   = RUN;
            end else begin
              hold        = 3'd1;
              pend_addr_d = bus.trap_addr_i;
              state_d     = JUMP_PEND;
            end
          end else if (bus.mdu_done_i) begin
            state_d = RUN;
          end else begin
            hold = 3'd3;
          end
        end

        JUMP_PEND: begin
          flush = 2'b11;
          // A late trap replaces the parked target and can redirect immediately.
          if (bus.trap_req_i) begin
            pend_addr_d = bus.trap_addr_i;
          end
          if (bus.ifetch_ready_i) begin
            jump_en   = 1'b1;
            jump_addr = bus.trap_req_i ? bus.trap_addr_i : pend_addr_q;
            state_d   = RUN;
          end else begin
            hold = 3'd1;
          end
        end

        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pend_addr_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      if ((hold != 3'd0) && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.jump_en_o   = jump_en;
  assign bus.jump_addr_o = jump_addr;
  assign bus.hold_o      = hold;
  assign bus.flush_o     = flush;
  assign bus.mdu_kill_o  = mdu_kill;
  assign bus.stall_cnt_o = stall_cnt_q;

endmodule
